// File: rtl/traffic_pkg.sv
// Shared types and constants for the multi-phase traffic sequencer.
package traffic_pkg;

  // FSM states; the encoding doubles as the state_flag output value.
  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

  // Bit positions inside one phase's vehicle lamp group {red, yellow, green}.
  localparam int VEH_GRN_BIT = 0;
  localparam int VEH_YEL_BIT = 1;
  localparam int VEH_RED_BIT = 2;

  // Bit positions inside one phase's pedestrian lamp group {stop, walk}.
  localparam int PED_WALK_BIT = 0;
  localparam int PED_STOP_BIT = 1;

  // One-hot lamp patterns derived from the bit positions above.
  localparam logic [2:0] LAMP_RED = 3'b001 << VEH_RED_BIT;
  localparam logic [2:0] LAMP_YEL = 3'b001 << VEH_YEL_BIT;
  localparam logic [2:0] LAMP_GRN = 3'b001 << VEH_GRN_BIT;
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [1:0] PED_STOP = 2'b01 << PED_STOP_BIT;
  localparam logic [1:0] PED_WALK = 2'b01 << PED_WALK_BIT;

  // Default interval constants, in ticks.
  localparam int DEF_GREEN_T  = 20;
  localparam int DEF_YELLOW_T = 3;
  localparam int ALLRED_T     = 2;
  localparam int PED_MIN_T    = 10;

  // Phase index width; never narrower than one bit.
  function automatic int pw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/phase_time_regfile.sv
// Per-phase green/yellow interval storage with a validated write port
// and a combinational read port.
module phase_time_regfile
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int TIME_W     = 7,
  parameter int DEF_GREEN  = DEF_GREEN_T,
  parameter int DEF_YELLOW = DEF_YELLOW_T,
  localparam int PW        = pw_of(NUM_PHASES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [PW-1:0]     cfg_phase,
  input  logic              cfg_sel,
  input  logic [TIME_W-1:0] cfg_time,
  output logic              cfg_err,
  input  logic [PW-1:0]     rd_phase,
  output logic [TIME_W-1:0] rd_green,
  output logic [TIME_W-1:0] rd_yellow
);

  localparam logic [PW:0] NP_W = (PW+1)'(NUM_PHASES);

  logic [TIME_W-1:0] green_mem  [NUM_PHASES];
  logic [TIME_W-1:0] yellow_mem [NUM_PHASES];
  logic              accept;
  logic              bad;

  assign accept = cfg_valid & cfg_ready;
  assign bad    = (cfg_time == {TIME_W{1'b0}}) || ({1'b0, cfg_phase} >= NP_W);

  // Storage update, write validation and the ready/error handshake flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
        green_mem[i]  <= TIME_W'(DEF_GREEN);
        yellow_mem[i] <= TIME_W'(DEF_YELLOW);
      end
    end else begin
      cfg_ready <= 1'b1;
      cfg_err   <= accept & bad;
      if (accept && !bad) begin
        if (cfg_sel) begin
          yellow_mem[cfg_phase] <= cfg_time;
        end else begin
          green_mem[cfg_phase] <= cfg_time;
        end
      end
    end
  end

  // Reads see the pre-edge contents, so a same-edge load uses the old value.
  assign rd_green  = green_mem[rd_phase];
  assign rd_yellow = yellow_mem[rd_phase];

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Multi-phase traffic-light sequencer: green/yellow/all-red cycling over
// NUM_PHASES approaches, pedestrian walk extension and flashing-yellow mode.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int TIME_W     = 7,
  parameter int T_ALLRED   = ALLRED_T,
  parameter int T_PED      = PED_MIN_T,
  parameter int DEF_GREEN  = DEF_GREEN_T,
  parameter int DEF_YELLOW = DEF_YELLOW_T,
  localparam int PW        = pw_of(NUM_PHASES)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [PW-1:0]           cfg_phase,
  input  logic                    cfg_sel,
  input  logic [TIME_W-1:0]       cfg_time,
  output logic                    cfg_err,
  input  logic [NUM_PHASES-1:0]   ped_req,
  input  logic                    flash_mode,
  output logic [3*NUM_PHASES-1:0] veh_light,
  output logic [2*NUM_PHASES-1:0] ped_light,
  output logic [PW-1:0]           active_phase,
  output logic [TIME_W-1:0]       time_remaining,
  output logic [1:0]              state_flag
);

  localparam logic [TIME_W-1:0] ONE_T   = TIME_W'(1'b1);
  localparam logic [TIME_W-1:0] ZERO_T  = {TIME_W{1'b0}};
  localparam logic [TIME_W-1:0] AR_T    = TIME_W'(T_ALLRED);
  localparam logic [TIME_W-1:0] PED_T   = TIME_W'(T_PED);
  localparam logic [TIME_W-1:0] DEF_G_T = TIME_W'(DEF_GREEN);
  localparam logic [PW-1:0]     LAST_P  = PW'(NUM_PHASES - 1);

  state_t                  state, state_n;
  logic [PW-1:0]           phase_n, nxt_phase, rd_phase;
  logic [TIME_W-1:0]       time_n, rd_green, rd_yellow;
  logic [NUM_PHASES-1:0]   pending, pending_n, walk, walk_n;
  logic                    flash_yel, flash_yel_n;

  phase_time_regfile #(
    .NUM_PHASES (NUM_PHASES),
    .TIME_W     (TIME_W),
    .DEF_GREEN  (DEF_GREEN),
    .DEF_YELLOW (DEF_YELLOW)
  ) u_regfile (
    .clock     (clock),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_phase (cfg_phase),
    .cfg_sel   (cfg_sel),
    .cfg_time  (cfg_time),
    .cfg_err   (cfg_err),
    .rd_phase  (rd_phase),
    .rd_green  (rd_green),
    .rd_yellow (rd_yellow)
  );

  // Vehicle lamp pattern for a given state, served phase and flash toggle.
  function automatic logic [3*NUM_PHASES-1:0] veh_decode(input state_t s,
                                                          input logic [PW-1:0] p,
                                                          input logic fy);
    logic [3*NUM_PHASES-1:0] v;
    v = {(3*NUM_PHASES){1'b0}};
    for (int i = 0; i < NUM_PHASES; i++) begin
      case (s)
        ST_GREEN:  v[3*i +: 3] = (PW'(i) == p) ? LAMP_GRN : LAMP_RED;
        ST_YELLOW: v[3*i +: 3] = (PW'(i) == p) ? LAMP_YEL : LAMP_RED;
        ST_ALLRED: v[3*i +: 3] = LAMP_RED;
        ST_FLASH:  v[3*i +: 3] = fy ? LAMP_YEL : LAMP_OFF;
        default:   v[3*i +: 3] = LAMP_RED;
      endcase
    end
    return v;
  endfunction

  // Pedestrian lamp pattern from the per-phase walk bits.
  function automatic logic [2*NUM_PHASES-1:0] ped_decode(input logic [NUM_PHASES-1:0] w);
    logic [2*NUM_PHASES-1:0] q;
    for (int i = 0; i < NUM_PHASES; i++) begin
      q[2*i +: 2] = w[i] ? PED_WALK : PED_STOP;
    end
    return q;
  endfunction

  assign nxt_phase  = (active_phase == LAST_P) ? {PW{1'b0}} : active_phase + PW'(1'b1);
  // In ALLRED the next load is the upcoming phase's green; otherwise the current phase.
  assign rd_phase   = (state == ST_ALLRED) ? nxt_phase : active_phase;
  assign state_flag = state;

  // Next-state, countdown, walk and pending computation.
  always_comb begin
    state_n     = state;
    phase_n     = active_phase;
    time_n      = time_remaining;
    walk_n      = walk;
    flash_yel_n = flash_yel;
    pending_n   = pending | ped_req;
    if (!tick) begin
      state_n = state;
    end else if (state == ST_FLASH) begin
      flash_yel_n = ~flash_yel;
      if (!flash_mode) begin
        // Leave via ALLRED; parking on the last phase makes the wrap land on phase 0.
        state_n     = ST_ALLRED;
        time_n      = AR_T;
        phase_n     = LAST_P;
        flash_yel_n = 1'b0;
      end else begin
        time_n = ZERO_T;
      end
    end else if (time_remaining > ONE_T) begin
      time_n = time_remaining - ONE_T;
    end else begin
      case (state)
        ST_GREEN: begin
          state_n = ST_YELLOW;
          time_n  = rd_yellow;
          walk_n  = {NUM_PHASES{1'b0}};
        end
        ST_YELLOW: begin
          state_n = ST_ALLRED;
          time_n  = AR_T;
        end
        ST_ALLRED: begin
          if (flash_mode) begin
            state_n     = ST_FLASH;
            time_n      = ZERO_T;
            flash_yel_n = 1'b1;
          end else begin
            state_n = ST_GREEN;
            phase_n = nxt_phase;
            walk_n  = {NUM_PHASES{1'b0}};
            if (pending[nxt_phase]) begin
              // Serve the walk; a press landing on this same edge stays latched.
              walk_n[nxt_phase]    = 1'b1;
              pending_n[nxt_phase] = ped_req[nxt_phase];
              time_n               = (rd_green > PED_T) ? rd_green : PED_T;
            end else begin
              time_n = rd_green;
            end
          end
        end
        default: begin
          state_n = ST_ALLRED;
          time_n  = AR_T;
          walk_n  = {NUM_PHASES{1'b0}};
        end
      endcase
    end
  end

  // FSM state and registered light/status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_GREEN;
      active_phase   <= {PW{1'b0}};
      time_remaining <= DEF_G_T;
      walk           <= {NUM_PHASES{1'b0}};
      pending        <= {NUM_PHASES{1'b0}};
      flash_yel      <= 1'b0;
      veh_light      <= veh_decode(ST_GREEN, {PW{1'b0}}, 1'b0);
      ped_light      <= ped_decode({NUM_PHASES{1'b0}});
    end else begin
      state          <= state_n;
      active_phase   <= phase_n;
      time_remaining <= time_n;
      walk           <= walk_n;
      pending        <= pending_n;
      flash_yel      <= flash_yel_n;
      veh_light      <= veh_decode(state_n, phase_n, flash_yel_n);
      ped_light      <= ped_decode(walk_n);
    end
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed self-checking bench for traffic_phase_sequencer (2 phases).
module tb_traffic_phase_sequencer;

  localparam int NP = 2;
  localparam int TW = 7;
  localparam int PW = 1;

  // Expected lamp words: veh = {p1 rgy-group, p0 group}, ped = {p1 {stop,walk}, p0}.
  localparam int VEH_G0 = 6'b100_001;
  localparam int VEH_Y0 = 6'b100_010;
  localparam int VEH_G1 = 6'b001_100;
  localparam int VEH_Y1 = 6'b010_100;
  localparam int VEH_AR = 6'b100_100;
  localparam int VEH_FY = 6'b010_010;
  localparam int VEH_FN = 6'b000_000;
  localparam int PED_NONE = 4'b10_10;
  localparam int PED_W0   = 4'b10_01;

  logic            clock = 1'b0;
  logic            reset;
  logic            tick;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [PW-1:0]   cfg_phase;
  logic            cfg_sel;
  logic [TW-1:0]   cfg_time;
  logic            cfg_err;
  logic [NP-1:0]   ped_req;
  logic            flash_mode;
  logic [3*NP-1:0] veh_light;
  logic [2*NP-1:0] ped_light;
  logic [PW-1:0]   active_phase;
  logic [TW-1:0]   time_remaining;
  logic [1:0]      state_flag;

  int n_chk  = 0;
  int n_pass = 0;

  traffic_phase_sequencer #(.NUM_PHASES(NP), .TIME_W(TW)) dut (
    .clock          (clock),
    .reset          (reset),
    .tick           (tick),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_phase      (cfg_phase),
    .cfg_sel        (cfg_sel),
    .cfg_time       (cfg_time),
    .cfg_err        (cfg_err),
    .ped_req        (ped_req),
    .flash_mode     (flash_mode),
    .veh_light      (veh_light),
    .ped_light      (ped_light),
    .active_phase   (active_phase),
    .time_remaining (time_remaining),
    .state_flag     (state_flag)
  );

  always #10 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_st(input string tag, input int st, input int ph, input int tm);
    chk({tag, ".state"}, int'(state_flag), st);
    chk({tag, ".phase"}, int'(active_phase), ph);
    chk({tag, ".time"}, int'(time_remaining), tm);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock) tick = 1'b1;
      @(negedge clock) tick = 1'b0;
    end
  endtask

  task automatic wr(input int ph, input logic sel, input int t);
    @(negedge clock);
    cfg_valid = 1'b1;
    cfg_phase = PW'(ph);
    cfg_sel   = sel;
    cfg_time  = TW'(t);
    @(negedge clock);
    cfg_valid = 1'b0;
  endtask

  task automatic press(input logic [NP-1:0] b);
    @(negedge clock) ped_req = b;
    @(negedge clock) ped_req = {NP{1'b0}};
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; cfg_valid = 1'b0; cfg_phase = '0; cfg_sel = 1'b0;
    cfg_time = '0; ped_req = '0; flash_mode = 1'b0;
    repeat (2) @(negedge clock);
    // Reset state
    chk("rst.ready", int'(cfg_ready), 0);
    chk("rst.err", int'(cfg_err), 0);
    chk_st("rst", 0, 0, 20);
    chk("rst.veh", int'(veh_light), VEH_G0);
    chk("rst.ped", int'(ped_light), PED_NONE);
    reset = 1'b0;
    @(negedge clock);
    chk("run.ready", int'(cfg_ready), 1);

    // Default cycle
    ticks(1);  chk_st("def.g0a", 0, 0, 19);
    ticks(18); chk_st("def.g0b", 0, 0, 1);
    ticks(1);  chk_st("def.y0", 1, 0, 3);  chk("def.y0.veh", int'(veh_light), VEH_Y0);
    ticks(3);  chk_st("def.ar", 2, 0, 2);  chk("def.ar.veh", int'(veh_light), VEH_AR);
    ticks(2);  chk_st("def.g1", 0, 1, 20); chk("def.g1.veh", int'(veh_light), VEH_G1);
    ticks(20); chk_st("def.y1", 1, 1, 3);  chk("def.y1.veh", int'(veh_light), VEH_Y1);
    ticks(3);  chk_st("def.ar2", 2, 1, 2);
    ticks(2);  chk_st("def.g0c", 0, 0, 20); chk("def.g0c.veh", int'(veh_light), VEH_G0);

    // Valid write during G0 for phase 1 green
    ticks(5);
    wr(1, 1'b0, 5);
    chk("wr.err", int'(cfg_err), 0);
    chk_st("wr.g0", 0, 0, 15);
    ticks(14); chk_st("wr.g0end", 0, 0, 1);
    ticks(1);  chk_st("wr.y0", 1, 0, 3);
    ticks(5);  chk_st("wr.g1", 0, 1, 5);
    ticks(4);  chk_st("wr.g1end", 0, 1, 1);
    ticks(1);  chk_st("wr.y1", 1, 1, 3);

    // Rejected write (zero time)
    wr(0, 1'b0, 0);
    chk("rej.err_hi", int'(cfg_err), 1);
    @(negedge clock);
    chk("rej.err_lo", int'(cfg_err), 0);
    ticks(5);  chk_st("rej.g0", 0, 0, 20);

    // Pedestrian extension
    wr(0, 1'b0, 4);
    ticks(25); chk_st("ped.g1", 0, 1, 5);
    press(2'b01);
    chk("ped.g1.ped", int'(ped_light), PED_NONE);
    ticks(8);  chk("ped.ar.ped", int'(ped_light), PED_NONE);
    ticks(2);  chk_st("ped.g0", 0, 0, 10); chk("ped.g0.walk", int'(ped_light), PED_W0);
    press(2'b01);
    ticks(9);  chk_st("ped.g0end", 0, 0, 1); chk("ped.g0end.walk", int'(ped_light), PED_W0);
    ticks(1);  chk_st("ped.y0", 1, 0, 3); chk("ped.y0.ped", int'(ped_light), PED_NONE);
    ticks(15); chk_st("ped.g0b", 0, 0, 10); chk("ped.g0b.walk", int'(ped_light), PED_W0);
    ticks(10); chk("ped.y0b.ped", int'(ped_light), PED_NONE);
    ticks(15); chk_st("ped.g0c", 0, 0, 4); chk("ped.g0c.ped", int'(ped_light), PED_NONE);

    // Flash entry/exit
    flash_mode = 1'b1;
    ticks(4);  chk_st("fl.y0", 1, 0, 3);
    ticks(3);  chk("fl.ar.state", int'(state_flag), 2);
    ticks(2);  chk("fl.on.state", int'(state_flag), 3); chk("fl.on.time", int'(time_remaining), 0);
    chk("fl.on.veh", int'(veh_light), VEH_FY);
    ticks(1);  chk("fl.off.veh", int'(veh_light), VEH_FN); chk("fl.off.time", int'(time_remaining), 0);
    ticks(1);  chk("fl.on2.veh", int'(veh_light), VEH_FY);
    flash_mode = 1'b0;
    ticks(1);  chk("fl.ar.state2", int'(state_flag), 2); chk("fl.ar.time", int'(time_remaining), 2);
    chk("fl.ar.veh", int'(veh_light), VEH_AR);
    ticks(2);  chk_st("fl.g0", 0, 0, 4); chk("fl.g0.veh", int'(veh_light), VEH_G0);

    // Reset during Y1 with a pending request
    ticks(14); chk_st("rm.y1", 1, 1, 3);
    press(2'b01);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_st("rm.rst", 0, 0, 20);
    chk("rm.veh", int'(veh_light), VEH_G0);
    chk("rm.ped", int'(ped_light), PED_NONE);
    chk("rm.ready", int'(cfg_ready), 0);
    ticks(20); chk_st("rm.y0", 1, 0, 3);
    ticks(5);  chk_st("rm.g1", 0, 1, 20);
    ticks(25); chk_st("rm.g0", 0, 0, 20); chk("rm.g0.ped", int'(ped_light), PED_NONE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
